noc_pkt_arbiter: RTL and testbench

- Shares one NoC output link between INPUTS packet sources: network-adapter modules (MPSIMPLE, DMA) and the debug bridge inside a compute tile.
- Arbitrates round-robin at packet granularity, never at flit granularity.
- Once an input wins, the grant is locked until that input's last flit completes its handshake.
- Also counts forwarded packets and flags packets that exceed a length limit.

---
 rtl/noc_pkg.sv | 19 +
 rtl/arb_rr.sv | 31 +++
 rtl/noc_pkt_arbiter.sv | 137 +++++++++++++
 tb/tb_noc_pkt_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type field layout, packet-arbiter state encoding
// and a small round-robin pointer helper.
package noc_pkg;

  localparam int FLIT_TYPE_WIDTH     = 2;
  // Bit positions inside the type field, which occupies the top bits of a flit.
  localparam int FLIT_TYPE_LAST_BIT  = 0;
  localparam int FLIT_TYPE_FIRST_BIT = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Stateless round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Callers own the pointer.
module arb_rr #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/noc_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC output link between
// several flit sources, with a packet counter and a sticky over-length flag.
module noc_pkt_arbiter
  import noc_pkg::*;
#(
  parameter int INPUTS      = 3,
  parameter int FLIT_WIDTH  = 34,
  parameter int MAX_PKT_LEN = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INPUTS-1:0]            grant,
  output logic [CNT_WIDTH-1:0]         pkt_cnt,
  output logic                         err_len
);

  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 2);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [LEN_W-1:0]     flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 err_len_q, err_len_d;

  logic [INPUTS-1:0]     pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic [IDX_W-1:0]      sel_idx;
  logic                  hs;
  logic [FLIT_WIDTH-1:0] flits [INPUTS];

  arb_rr #(
    .N     (INPUTS),
    .IDX_W (IDX_W)
  ) u_arb_rr (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < INPUTS; i++) begin
      flits[i] = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

  assign hs = out_valid & out_ready;

  // The IDLE and LOCKED paths share one update: the IDLE flit count is always
  // zero, so the first non-last handshake lands on one and takes the lock.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_len_d  = err_len_q;
    if (hs) begin
      if (out_last) begin
        state_d    = IDLE;
        rr_ptr_d   = IDX_W'(rr_wrap_inc(int'(sel_idx), INPUTS));
        pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(1);
        flit_cnt_d = '0;
      end else begin
        if (flit_cnt_q == LEN_W'(MAX_PKT_LEN)) begin
          err_len_d = 1'b1;
        end
        if (flit_cnt_q != LEN_W'(MAX_PKT_LEN + 1)) begin
          flit_cnt_d = flit_cnt_q + LEN_W'(1);
        end
        if (state_q == IDLE) begin
          state_d = LOCKED;
          owner_d = sel_idx;
        end
      end
    end
  end

  // Gated by rst_n because the IDLE grant is combinational from in_valid and
  // the link must go quiet the moment reset is asserted.
  always_comb begin
    sel_idx   = pick_idx;
    grant     = '0;
    out_flit  = '0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        sel_idx        = owner_q;
        grant[owner_q] = 1'b1;
      end else begin
        grant = pick_gnt;
      end
      if (|grant) begin
        out_flit  = flits[sel_idx];
        out_last  = in_last[sel_idx];
        out_valid = in_valid[sel_idx];
      end
    end
    in_ready = grant & {INPUTS{out_ready}};
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_noc_pkt_arbiter.sv
// Scoreboard bench for noc_pkt_arbiter: sources replay flit queues, expected
// output flits are queued in arbitration order and popped on each handshake.
module tb_noc_pkt_arbiter;

  localparam int INPUTS      = 3;
  localparam int FLIT_WIDTH  = 34;
  localparam int MAX_PKT_LEN = 4;
  localparam int CNT_WIDTH   = 16;

  typedef struct {
    logic [FLIT_WIDTH-1:0] flit;
    logic                  last;
    int                    src;
  } flit_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [INPUTS*FLIT_WIDTH-1:0] in_flit = '0;
  logic [INPUTS-1:0]            in_last = '0;
  logic [INPUTS-1:0]            in_valid = '0;
  logic [INPUTS-1:0]            in_ready;
  logic [FLIT_WIDTH-1:0]        out_flit;
  logic                         out_last;
  logic                         out_valid;
  logic                         out_ready = 1'b1;
  logic [INPUTS-1:0]            grant;
  logic [CNT_WIDTH-1:0]         pkt_cnt;
  logic                         err_len;

  always #5 clk = ~clk;

  noc_pkt_arbiter #(
    .INPUTS      (INPUTS),
    .FLIT_WIDTH  (FLIT_WIDTH),
    .MAX_PKT_LEN (MAX_PKT_LEN),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .pkt_cnt   (pkt_cnt),
    .err_len   (err_len)
  );

  flit_t             srcQ [INPUTS][$];
  flit_t             expQ [$];
  int                srcDelay [INPUTS];
  int                srcPauseAt [INPUTS];
  int                srcPauseLen [INPUTS];
  int                srcSent [INPUTS];
  logic              wasPaused [INPUTS];
  logic              readyQ [$];
  int                hsLog [$];
  int                cycleNum = 0;
  int                compared = 0;
  int                mismatched = 0;
  int                pktExp = 0;
  logic              errExp = 1'b0;
  int                curLen = 0;
  logic [INPUTS-1:0] lockMask = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleNum);
    end
  endtask

  function automatic logic [INPUTS-1:0] onehot(input int src);
    return INPUTS'(1) << src;
  endfunction

  function automatic logic [FLIT_WIDTH-1:0] mkFlit(input int src, input int tag, input int k, input int len);
    logic [31:0] body;
    body = 32'((tag << 8) | (src << 4) | k);
    return {k == 0, k == len - 1, body};
  endfunction

  task automatic loadPacket(input int src, input int len, input int tag);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.flit = mkFlit(src, tag, k, len);
      f.last = (k == len - 1);
      f.src  = src;
      srcQ[src].push_back(f);
    end
  endtask

  task automatic expectFlits(input int src, input int len, input int tag, input int count);
    flit_t f;
    for (int k = 0; k < count; k++) begin
      f.flit = mkFlit(src, tag, k, len);
      f.last = (k == len - 1);
      f.src  = src;
      expQ.push_back(f);
    end
  endtask

  task automatic sendPacket(input int src, input int len, input int tag);
    loadPacket(src, len, tag);
    expectFlits(src, len, tag, len);
  endtask

  task automatic clearSources();
    for (int i = 0; i < INPUTS; i++) begin
      srcQ[i].delete();
      srcDelay[i]    = 0;
      srcPauseAt[i]  = -1;
      srcPauseLen[i] = 0;
      srcSent[i]     = 0;
      wasPaused[i]   = 1'b0;
    end
  endtask

  task automatic driveInputs();
    logic [INPUTS-1:0]            v;
    logic [INPUTS-1:0]            l;
    logic [INPUTS*FLIT_WIDTH-1:0] f;
    v = '0;
    l = '0;
    f = '0;
    for (int i = 0; i < INPUTS; i++) begin
      wasPaused[i] = (srcPauseLen[i] > 0) && (srcSent[i] == srcPauseAt[i]);
      if (srcQ[i].size() > 0 && srcDelay[i] == 0 && !wasPaused[i]) begin
        v[i] = 1'b1;
        l[i] = srcQ[i][0].last;
        f[i*FLIT_WIDTH +: FLIT_WIDTH] = srcQ[i][0].flit;
      end
    end
    in_valid  = v;
    in_last   = l;
    in_flit   = f;
    out_ready = (readyQ.size() > 0) ? readyQ.pop_front() : 1'b1;
  endtask

  task automatic sampleOutputs();
    flit_t e;
    if (lockMask != '0) begin
      checkOutput("grantLock", grant, lockMask);
      checkOutput("lockReady", in_ready, lockMask & {INPUTS{out_ready}});
      if ((in_valid & lockMask) == '0) checkOutput("pauseValid", out_valid, 0);
    end
    if (out_valid && out_ready) begin
      hsLog.push_back(cycleNum);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFlit", expQ.size(), 1);
      end else begin
        e = expQ.pop_front();
        checkOutput("flit", out_flit, e.flit);
        checkOutput("last", out_last, e.last);
        checkOutput("grant", grant, onehot(e.src));
        checkOutput("inReady", in_ready, onehot(e.src));
        checkOutput("pktCnt", pkt_cnt, pktExp);
        checkOutput("errLen", err_len, errExp);
        if (!e.last && curLen == MAX_PKT_LEN) errExp = 1'b1;
        if (e.last) begin
          curLen = 0;
          pktExp++;
          if (lockMask == onehot(e.src)) lockMask = '0;
        end else begin
          curLen++;
        end
      end
      for (int i = 0; i < INPUTS; i++) begin
        if (in_valid[i] && in_ready[i] && srcQ[i].size() > 0) begin
          srcQ[i].delete(0);
          srcSent[i]++;
        end
      end
    end
    for (int i = 0; i < INPUTS; i++) begin
      if (wasPaused[i]) srcPauseLen[i]--;
      if (srcQ[i].size() > 0 && srcDelay[i] > 0) srcDelay[i]--;
    end
  endtask

  task automatic applyStimulus();
    driveInputs();
    #3;
    sampleOutputs();
    @(posedge clk);
    #1;
    cycleNum++;
  endtask

  function automatic int pendingFlits();
    int n = 0;
    for (int i = 0; i < INPUTS; i++) n += srcQ[i].size();
    return n;
  endfunction

  task automatic runUntilDrained(input int maxCycles);
    int n = 0;
    while ((expQ.size() > 0 || pendingFlits() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drained", expQ.size(), 0);
    checkOutput("srcDrained", pendingFlits(), 0);
    expQ.delete();
    readyQ.delete();
    lockMask = '0;
    clearSources();
    applyStimulus();
  endtask

  function automatic int hsGap(input int a, input int b);
    return (hsLog.size() > b) ? hsLog[b] - hsLog[a] : -1;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearSources();

    // Reset holds every output quiet even with all inputs requesting.
    in_valid = '1;
    in_last  = '1;
    in_flit  = '1;
    #12;
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstPktCnt", pkt_cnt, 0);
    checkOutput("rstErrLen", err_len, 0);
    in_valid = '0;
    in_last  = '0;
    in_flit  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-flit packets from every input: grants 0,1,2,0 back to back.
    hsLog.delete();
    loadPacket(0, 1, 1);
    loadPacket(0, 1, 2);
    loadPacket(1, 1, 1);
    loadPacket(2, 1, 1);
    expectFlits(0, 1, 1, 1);
    expectFlits(1, 1, 1, 1);
    expectFlits(2, 1, 1, 1);
    expectFlits(0, 1, 2, 1);
    runUntilDrained(20);
    checkOutput("rrBackToBack", hsGap(0, 3), 3);
    checkOutput("rrPktCnt", pkt_cnt, 4);

    // Input 1 holds a 4-flit lock while input 0 waits from cycle 2.
    hsLog.delete();
    loadPacket(1, 4, 3);
    loadPacket(0, 1, 3);
    srcDelay[0] = 2;
    expectFlits(1, 4, 3, 4);
    expectFlits(0, 1, 3, 1);
    lockMask = 3'b010;
    runUntilDrained(30);
    checkOutput("switchGap", hsGap(3, 4), 1);

    // Input 2 with out_ready toggling: 3 flits on every other cycle.
    hsLog.delete();
    sendPacket(2, 3, 4);
    for (int k = 0; k < 6; k++) readyQ.push_back(k % 2 == 0);
    lockMask = 3'b100;
    runUntilDrained(30);
    checkOutput("toggleSpacing", hsGap(0, 2), 4);

    // Pointer should now sit at 0 after the wrap from input 2.
    sendPacket(0, 1, 5);
    sendPacket(1, 1, 5);
    sendPacket(2, 1, 5);
    runUntilDrained(20);
    checkOutput("wrapPktCnt", pkt_cnt, 10);

    // Owner 1 stalls 3 cycles mid-packet while input 0 keeps requesting.
    hsLog.delete();
    loadPacket(1, 3, 6);
    loadPacket(0, 1, 6);
    srcDelay[0]    = 1;
    srcPauseAt[1]  = 1;
    srcPauseLen[1] = 3;
    expectFlits(1, 3, 6, 3);
    expectFlits(0, 1, 6, 1);
    lockMask = 3'b010;
    runUntilDrained(30);
    checkOutput("pauseSpan", hsGap(0, 1), 4);

    // Over-length packet: err_len rises on the 5th flit and stays set.
    sendPacket(0, 6, 7);
    lockMask = 3'b001;
    runUntilDrained(30);
    checkOutput("errSticky", err_len, 1);
    checkOutput("errPktCnt", pkt_cnt, 13);

    // Asynchronous reset in the middle of a locked packet.
    hsLog.delete();
    loadPacket(2, 3, 8);
    expectFlits(2, 3, 8, 1);
    applyStimulus();
    checkOutput("preRstHs", hsLog.size(), 1);
    driveInputs();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", in_ready, 0);
    checkOutput("midRstOutValid", out_valid, 0);
    checkOutput("midRstGrant", grant, 0);
    clearSources();
    expQ.delete();
    pktExp   = 0;
    errExp   = 1'b0;
    curLen   = 0;
    in_valid = '0;
    in_last  = '0;
    in_flit  = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postRstPktCnt", pkt_cnt, 0);
    checkOutput("postRstErrLen", err_len, 0);
    sendPacket(0, 1, 9);
    sendPacket(1, 1, 9);
    sendPacket(2, 1, 9);
    runUntilDrained(20);
    checkOutput("postRstPkts", pkt_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
